// File: rtl/stars_bus_pkg.sv
// Shared types for the fetch/data bus arbiter.
package stars_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    typedef enum logic {
        FETCH,
        DATA
    } grant_t;

    localparam logic [3:0] FETCH_SEL = 4'hF;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one memory bus,
// round-robin on contention, aborting any transaction the bus holds busy too long.
module mem_arbiter
    import stars_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ack,
    output logic [31:0] fetch_data,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_sel,
    output logic        data_ack,
    output logic [31:0] data_rdata,
    output logic        bus_err,
    output logic        read_i,
    output logic        write_i,
    output logic [31:0] adr_i,
    output logic [31:0] cpu_dat_i,
    output logic [3:0]  sel_i,
    input  logic [31:0] cpu_dat_o,
    input  logic        busy_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    arb_state_t      state_q, state_d;
    grant_t          last_grant_q, last_grant_d;
    grant_t          owner_q, owner_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     wdat_q, wdat_d;
    logic [3:0]      sel_q, sel_d;
    logic            we_q, we_d;
    logic            fetch_ack_q, fetch_ack_d;
    logic            data_ack_q, data_ack_d;
    logic            bus_err_q, bus_err_d;
    logic [31:0]     fetch_data_q, fetch_data_d;
    logic [31:0]     data_rdata_q, data_rdata_d;

    logic   fetch_elig, data_elig, can_grant, done, abort;
    grant_t grant_sel;

    // A requester whose ack is showing this cycle has not yet had a chance to drop its req.
    assign fetch_elig = fetch_req & ~fetch_ack_q;
    assign data_elig  = data_req & ~data_ack_q;
    assign can_grant  = (state_q == IDLE) & ~busy_o & (fetch_elig | data_elig);
    assign done       = (state_q == WAIT) & ~busy_o;
    assign abort      = (state_q == WAIT) & busy_o & (cnt_q == CntW'(TIMEOUT));

    always_comb begin
        if (fetch_elig && data_elig) begin
            grant_sel = (last_grant_q == DATA) ? FETCH : DATA;
        end else begin
            grant_sel = fetch_elig ? FETCH : DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= DATA;
            owner_q      <= FETCH;
            cnt_q        <= '0;
            adr_q        <= '0;
            wdat_q       <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            fetch_ack_q  <= 1'b0;
            data_ack_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            fetch_data_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            adr_q        <= adr_d;
            wdat_q       <= wdat_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            fetch_ack_q  <= fetch_ack_d;
            data_ack_q   <= data_ack_d;
            bus_err_q    <= bus_err_d;
            fetch_data_q <= fetch_data_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (can_grant) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (done || abort) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        adr_d        = adr_q;
        wdat_d       = wdat_q;
        sel_d        = sel_q;
        we_d         = we_q;
        fetch_ack_d  = 1'b0;
        data_ack_d   = 1'b0;
        bus_err_d    = 1'b0;
        fetch_data_d = fetch_data_q;
        data_rdata_d = data_rdata_q;

        if (can_grant) begin
            owner_d      = grant_sel;
            last_grant_d = grant_sel;
            cnt_d        = '0;
            if (grant_sel == FETCH) begin
                adr_d  = fetch_addr;
                wdat_d = '0;
                sel_d  = FETCH_SEL;
                we_d   = 1'b0;
            end else begin
                adr_d  = data_addr;
                wdat_d = data_wdata;
                sel_d  = data_sel;
                we_d   = data_we;
            end
        end

        if (done || abort) begin
            bus_err_d = abort;
            if (owner_q == FETCH) begin
                fetch_ack_d  = 1'b1;
                fetch_data_d = done ? cpu_dat_o : '0;
            end else begin
                data_ack_d = 1'b1;
                if (!we_q) data_rdata_d = done ? cpu_dat_o : '0;
            end
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_comb begin
        read_i  = 1'b0;
        write_i = 1'b0;
        if (state_q == ISSUE) begin
            read_i  = ~we_q;
            write_i = we_q;
        end
    end

    assign fetch_ack  = fetch_ack_q;
    assign data_ack   = data_ack_q;
    assign bus_err    = bus_err_q;
    assign fetch_data = fetch_data_q;
    assign data_rdata = data_rdata_q;
    assign adr_i      = adr_q;
    assign cpu_dat_i  = wdat_q;
    assign sel_i      = sel_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a bus-slave model predicts each response when the
// strobe appears, and a separate monitor checks it when the ack shows up.
module tb_mem_arbiter;

    localparam int unsigned TO = 6;

    typedef struct {
        bit          is_fetch;
        bit          err;
        bit          is_store;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req, fetch_ack;
    logic [31:0] fetch_addr, fetch_data;
    logic        data_req, data_we, data_ack;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_sel;
    logic        bus_err, read_i, write_i;
    logic [31:0] adr_i, cpu_dat_i, cpu_dat_o;
    logic [3:0]  sel_i;
    logic        busy_o;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_strobe_cyc = -1;
    bit   f_v = 0, d_v = 0;
    bit   random_bus = 0, force_busy = 0;
    exp_t exp_q[$];
    int   plan[$];
    bit   ack_log[$];
    logic [31:0] m_fdata = '0, m_rdata = '0;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ack  (fetch_ack),
        .fetch_data (fetch_data),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_sel   (data_sel),
        .data_ack   (data_ack),
        .data_rdata (data_rdata),
        .bus_err    (bus_err),
        .read_i     (read_i),
        .write_i    (write_i),
        .adr_i      (adr_i),
        .cpu_dat_i  (cpu_dat_i),
        .sel_i      (sel_i),
        .cpu_dat_o  (cpu_dat_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'h13;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory contents seen by the bus slave.
    assign cpu_dat_o = rd_fn(adr_i);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick_wait();
        if ($urandom_range(0, 19) == 0) return TO + 2;
        return int'($urandom_range(0, 3));
    endfunction

    // Bus slave: decides busy cycles per transaction and predicts the response.
    initial begin
        int          w;
        bit          own_f, killed;
        exp_t        e;
        logic [31:0] a0, d0;
        logic [3:0]  s0;
        busy_o = 1'b0;
        forever begin
            @(negedge clk);
            if (read_i || write_i) begin
                last_strobe_cyc = cyc;
                if (random_bus) w = pick_wait();
                else w = (plan.size() > 0) ? plan.pop_front() : 0;
                own_f = f_v && (adr_i == fetch_addr);
                if (own_f) begin
                    chk("fetch_strobe", 64'({read_i, write_i}), 64'(2'b10));
                    chk("fetch_sel", 64'(sel_i), 64'(4'hF));
                    chk("fetch_wdata", 64'(cpu_dat_i), 64'd0);
                end else begin
                    chk("data_pending", 64'(d_v), 64'd1);
                    chk("data_addr", 64'(adr_i), 64'(data_addr));
                    chk("data_strobe", 64'({read_i, write_i}), 64'({!data_we, data_we}));
                    chk("data_sel", 64'(sel_i), 64'(data_sel));
                    if (data_we) chk("store_wdata", 64'(cpu_dat_i), 64'(data_wdata));
                end
                e.is_fetch = own_f;
                e.err      = (w > int'(TO));
                e.is_store = !own_f && data_we;
                e.data     = e.err ? 32'h0 : rd_fn(adr_i);
                e.cyc      = cyc + 2 + ((w > int'(TO)) ? int'(TO) : w);
                exp_q.push_back(e);
                a0 = adr_i;
                d0 = cpu_dat_i;
                s0 = sel_i;
                killed = 0;
                busy_o = (w > 0);
                repeat (w + 1) begin
                    @(negedge clk);
                    if (!rst) killed = 1;
                    if (!killed) begin
                        chk("strobe_once", 64'({read_i, write_i}), 64'd0);
                        chk("adr_hold", 64'(adr_i), 64'(a0));
                        chk("dat_hold", 64'(cpu_dat_i), 64'(d0));
                        chk("sel_hold", 64'(sel_i), 64'(s0));
                    end
                end
                busy_o = 1'b0;
            end else begin
                busy_o = force_busy || (random_bus && $urandom_range(0, 3) == 0);
            end
        end
    end

    // Monitor: pops the prediction whenever an ack appears.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (fetch_ack || data_ack) begin
                ack_log.push_back(fetch_ack);
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 64'({fetch_ack, data_ack}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_owner", 64'({fetch_ack, data_ack}), e.is_fetch ? 64'd2 : 64'd1);
                    chk("bus_err", 64'(bus_err), 64'(e.err));
                    chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                    if (e.is_fetch) m_fdata = e.data;
                    else if (!e.is_store) m_rdata = e.data;
                    chk("fetch_data", 64'(fetch_data), 64'(m_fdata));
                    chk("data_rdata", 64'(data_rdata), 64'(m_rdata));
                end
            end
        end
    end

    task automatic wait_fetch(input bit may_drop, output int ack_cyc);
        ack_cyc = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (fetch_ack) begin
                ack_cyc = cyc;
                f_v = 0;
                break;
            end
            if (may_drop && read_i && adr_i == fetch_addr && $urandom_range(0, 1) == 1)
                fetch_req = 1'b0;
        end
        if (ack_cyc < 0) chk("fetch_ack_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_data(input bit may_drop, output int ack_cyc);
        ack_cyc = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (data_ack) begin
                ack_cyc = cyc;
                d_v = 0;
                break;
            end
            if (may_drop && (read_i || write_i) && adr_i == data_addr &&
                $urandom_range(0, 1) == 1)
                data_req = 1'b0;
        end
        if (ack_cyc < 0) chk("data_ack_timeout", 64'd0, 64'd1);
    endtask

    task automatic start_fetch(input logic [31:0] a);
        fetch_addr = a;
        f_v        = 1;
        fetch_req  = 1'b1;
    endtask

    task automatic start_data(input logic [31:0] a, input logic we, input logic [31:0] wd,
                              input logic [3:0] sel);
        data_addr  = a;
        data_we    = we;
        data_wdata = wd;
        data_sel   = sel;
        d_v        = 1;
        data_req   = 1'b1;
    endtask

    task automatic run_fetch(input int n);
        int ac;
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            @(posedge clk); #1;
            a = $urandom();
            a[31] = 1'b0;
            a[1:0] = 2'b00;
            start_fetch(a);
            wait_fetch(1, ac);
            @(posedge clk); #1;
            fetch_req = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    task automatic run_data(input int n);
        int ac;
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            @(posedge clk); #1;
            a = $urandom();
            a[31] = 1'b1;
            a[1:0] = 2'b00;
            start_data(a, 1'($urandom_range(0, 1)), $urandom(), 4'($urandom_range(1, 15)));
            wait_data(1, ac);
            @(posedge clk); #1;
            data_req = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, ac, k, n0;
        rst = 1'b0;
        fetch_req = 1'b0;
        fetch_addr = '0;
        data_req = 1'b0;
        data_we = 1'b0;
        data_addr = '0;
        data_wdata = '0;
        data_sel = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_strobes_acks", 64'({read_i, write_i, fetch_ack, data_ack, bus_err}), 64'd0);
        chk("rst_bus", 64'(adr_i | cpu_dat_i | {28'h0, sel_i}), 64'd0);
        chk("rst_read_data", 64'(fetch_data | data_rdata), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Fetch, no wait states.
        @(posedge clk); #1;
        t0 = cyc;
        start_fetch(32'h10);
        wait_fetch(0, ac);
        chk("fetch_strobe_cycle", 64'(last_strobe_cyc), 64'(t0 + 1));
        chk("fetch_latency", 64'(ac), 64'(t0 + 3));
        chk("fetch_word", 64'(fetch_data), 64'h13);
        @(posedge clk); #1;
        fetch_req = 1'b0;

        // Load, then a store that must leave the load result in place.
        @(posedge clk); #1;
        start_data(32'h20, 1'b0, 32'h0, 4'hF);
        wait_data(0, ac);
        @(posedge clk); #1;
        data_req = 1'b0;
        @(posedge clk); #1;
        t0 = cyc;
        plan.push_back(2);
        start_data(32'h8, 1'b1, 32'hCAFE_F00D, 4'h3);
        wait_data(0, ac);
        chk("store_strobe_cycle", 64'(last_strobe_cyc), 64'(t0 + 1));
        chk("store_latency", 64'(ac), 64'(t0 + 5));
        chk("store_keeps_rdata", 64'(data_rdata), 64'(rd_fn(32'h20)));
        @(posedge clk); #1;
        data_req = 1'b0;

        // Load against a bus stuck busy, then a normal load.
        @(posedge clk); #1;
        t0 = cyc;
        plan.push_back(TO + 2);
        start_data(32'h30, 1'b0, 32'h0, 4'hF);
        wait_data(0, ac);
        chk("timeout_latency", 64'(ac), 64'(t0 + 3 + int'(TO)));
        @(posedge clk); #1;
        data_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        t0 = cyc;
        plan.push_back(1);
        start_data(32'h40, 1'b0, 32'h0, 4'hF);
        wait_data(0, ac);
        chk("after_timeout_latency", 64'(ac), 64'(t0 + 4));
        @(posedge clk); #1;
        data_req = 1'b0;

        // Request arrives while the bus is busy in IDLE.
        @(posedge clk); #1;
        force_busy = 1;
        @(posedge clk); #1;
        start_fetch(32'h50);
        repeat (3) @(posedge clk);
        #1;
        k = cyc;
        force_busy = 0;
        wait_fetch(0, ac);
        chk("busy_idle_strobe", 64'(last_strobe_cyc), 64'(k + 1));
        chk("busy_idle_latency", 64'(ac), 64'(k + 3));
        @(posedge clk); #1;
        fetch_req = 1'b0;

        // Reset in the middle of WAIT abandons the load.
        @(posedge clk); #1;
        plan.push_back(10);
        start_data(32'h60, 1'b0, 32'h0, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        data_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        d_v = 0;
        m_fdata = '0;
        m_rdata = '0;
        @(negedge clk);
        chk("wait_rst_strobes_acks", 64'({read_i, write_i, fetch_ack, data_ack, bus_err}), 64'd0);
        chk("wait_rst_bus", 64'(adr_i | cpu_dat_i | {28'h0, sel_i}), 64'd0);
        chk("wait_rst_read_data", 64'(fetch_data | data_rdata), 64'd0);
        repeat (14) @(posedge clk);

        // Both requesters held high: grants must alternate starting with fetch.
        #1;
        n0 = ack_log.size();
        start_fetch(32'h100);
        start_data(32'h200, 1'b0, 32'h0, 4'hF);
        for (int i = 0; i < 200 && ack_log.size() < n0 + 3; i++) @(posedge clk);
        #1;
        fetch_req = 1'b0;
        data_req = 1'b0;
        chk("rr_progress", 64'(ack_log.size() >= n0 + 3), 64'd1);
        if (ack_log.size() >= n0 + 3) begin
            chk("rr_first_fetch", 64'(ack_log[n0]), 64'd1);
            chk("rr_second_data", 64'(ack_log[n0 + 1]), 64'd0);
            chk("rr_third_fetch", 64'(ack_log[n0 + 2]), 64'd1);
        end
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        f_v = 0;
        d_v = 0;

        // Randomized traffic from both requesters.
        random_bus = 1;
        fork
            run_fetch(40);
            run_data(40);
        join
        random_bus = 0;
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
